// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared encodings and beep counts for the beep scheduler
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int SRC_KEY   = 0;
  localparam int SRC_COIN  = 1;
  localparam int SRC_DONE  = 2;
  localparam int SRC_FAULT = 3;

  localparam logic [2:0] CNT_KEY   = 3'd1;
  localparam logic [2:0] CNT_COIN  = 3'd2;
  localparam logic [2:0] CNT_DONE  = 3'd3;
  localparam logic [2:0] CNT_FAULT = 3'd5;

endpackage

// File: rtl/beep_prio_enc.sv
// rtl/beep_prio_enc.sv - fixed-priority pick of the pending source and its beep count
module beep_prio_enc
  import beep_pkg::*;
(
  input  logic [3:0] pend,
  output logic [3:0] sel,
  output logic [2:0] count
);

  always_comb begin
    sel   = 4'b0000;
    count = 3'd0;
    if (pend[SRC_FAULT]) begin
      sel[SRC_FAULT] = 1'b1;
      count          = CNT_FAULT;
    end else if (pend[SRC_DONE]) begin
      sel[SRC_DONE] = 1'b1;
      count         = CNT_DONE;
    end else if (pend[SRC_COIN]) begin
      sel[SRC_COIN] = 1'b1;
      count         = CNT_COIN;
    end else if (pend[SRC_KEY]) begin
      sel[SRC_KEY] = 1'b1;
      count        = CNT_KEY;
    end
  end

endmodule

// File: rtl/beep_sched.sv
// rtl/beep_sched.sv - latches beep requests and plays one source's pattern at a time
module beep_sched
  import beep_pkg::*;
#(
  parameter logic [23:0] ON_TICKS  = 24'd10_000_000,
  parameter logic [23:0] OFF_TICKS = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic [3:0] grant,
  output logic       merged
);

  state_t      state, state_nx;
  logic [23:0] cnt, cnt_nx;
  logic [2:0]  left, left_nx;
  logic [3:0]  pend, pend_nx;
  logic [3:0]  grant_nx, clr;
  logic [3:0]  sel;
  logic [2:0]  count;
  logic        beep_nx, busy_nx, merged_nx;

  beep_prio_enc u_prio (
    .pend  (pend),
    .sel   (sel),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    left_nx  = left;
    grant_nx = grant;
    clr      = 4'b0000;
    case (state)
      ST_IDLE: begin
        if ((pend != 4'b0000) && !mute) begin
          state_nx = ST_ON;
          clr      = sel;
          grant_nx = sel;
          left_nx  = count;
          cnt_nx   = ON_TICKS - 24'd1;
        end
      end
      ST_ON: begin
        if (mute) begin
          state_nx = ST_IDLE;
          grant_nx = 4'b0000;
          cnt_nx   = 24'd0;
          left_nx  = 3'd0;
        end else if (cnt == 24'd0) begin
          state_nx = ST_OFF;
          left_nx  = left - 3'd1;
          cnt_nx   = OFF_TICKS - 24'd1;
        end else begin
          cnt_nx = cnt - 24'd1;
        end
      end
      ST_OFF: begin
        if (mute) begin
          state_nx = ST_IDLE;
          grant_nx = 4'b0000;
          cnt_nx   = 24'd0;
          left_nx  = 3'd0;
        end else if (cnt == 24'd0) begin
          if (left != 3'd0) begin
            state_nx = ST_ON;
            cnt_nx   = ON_TICKS - 24'd1;
          end else begin
            state_nx = ST_IDLE;
            grant_nx = 4'b0000;
          end
        end else begin
          cnt_nx = cnt - 24'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = 4'b0000;
        cnt_nx   = 24'd0;
        left_nx  = 3'd0;
      end
    endcase
  end

  // A new request in the grant cycle survives the clear.
  always_comb begin
    pend_nx   = (pend & ~clr) | req;
    merged_nx = |(req & pend);
    beep_nx   = (state_nx != ST_ON);
    busy_nx   = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 24'd0;
      left   <= 3'd0;
      pend   <= 4'b0000;
      grant  <= 4'b0000;
      beep   <= 1'b1;
      busy   <= 1'b0;
      merged <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      left   <= left_nx;
      pend   <= pend_nx;
      grant  <= grant_nx;
      beep   <= beep_nx;
      busy   <= busy_nx;
      merged <= merged_nx;
    end
  end

endmodule

// File: tb/tb_beep_sched.sv
// tb/tb_beep_sched.sv - directed scenarios for beep_sched with ON_TICKS=4, OFF_TICKS=3
module tb_beep_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mute = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       beep, busy, merged;
  logic [3:0] grant;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       beep;
    logic       busy;
    logic [3:0] grant;
  } exp_t;

  beep_sched #(
    .ON_TICKS  (24'd4),
    .OFF_TICKS (24'd3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .mute   (mute),
    .beep   (beep),
    .busy   (busy),
    .grant  (grant),
    .merged (merged)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sequence of n beeps starting (first low cycle) at cycle s; period 7 = 4 low + 3 high.
  function automatic exp_t seq_at(input int c, input int s, input int n, input logic [3:0] g);
    exp_t x;
    x.beep  = 1'b1;
    x.busy  = 1'b0;
    x.grant = 4'b0000;
    if (c >= s && c < s + 7 * n) begin
      x.busy  = 1'b1;
      x.grant = g;
      x.beep  = ((c - s) % 7) >= 4;
    end
    return x;
  endfunction

  function automatic exp_t exp_at(input int id, input int c);
    case (id)
      2:       return seq_at(c, 2, 2, 4'b0010);
      3:       return (c < 38) ? seq_at(c, 2, 5, 4'b1000) : seq_at(c, 38, 1, 4'b0001);
      4:       return (c < 17) ? seq_at(c, 2, 2, 4'b0010) : seq_at(c, 17, 1, 4'b0001);
      5:       return (c <= 10) ? seq_at(c, 2, 3, 4'b0100) : seq_at(c, 15, 2, 4'b0010);
      6:       return (c <= 3) ? seq_at(c, 2, 1, 4'b0001) : seq_at(c, 0, 0, 4'b0000);
      default: return seq_at(c, 0, 0, 4'b0000);
    endcase
  endfunction

  function automatic logic [3:0] stim_req(input int id, input int e);
    case (id)
      2:       return (e == 0) ? 4'b0010 : 4'b0000;
      3:       return (e == 0) ? 4'b1001 : 4'b0000;
      4:       return (e == 0) ? 4'b0010 : ((e == 3 || e == 6) ? 4'b0001 : 4'b0000);
      5:       return (e == 0) ? 4'b0100 : ((e == 1) ? 4'b0010 : 4'b0000);
      6:       return (e == 0) ? 4'b0001 : ((e == 2) ? 4'b0100 : 4'b0000);
      default: return 4'b0000;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    mute  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst beep", {31'd0, beep}, 32'd1);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst grant", {28'd0, grant}, 32'd0);
    check_eq("rst merged", {31'd0, merged}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Edge e samples the stimulus; outputs seen after it belong to cycle e+1.
  task automatic run_scn(input int id, input int n_edges);
    exp_t x;
    logic mg;
    for (int e = 0; e < n_edges; e++) begin
      req   = stim_req(id, e);
      mute  = (id == 5) && (e >= 10) && (e <= 13);
      rst_n = !((id == 6) && (e == 3));
      @(posedge clk);
      #1;
      x  = exp_at(id, e + 1);
      mg = (id == 4) && (e + 1 == 7);
      check_eq($sformatf("s%0d c%0d beep", id, e + 1), {31'd0, beep}, {31'd0, x.beep});
      check_eq($sformatf("s%0d c%0d busy", id, e + 1), {31'd0, busy}, {31'd0, x.busy});
      check_eq($sformatf("s%0d c%0d grant", id, e + 1), {28'd0, grant}, {28'd0, x.grant});
      check_eq($sformatf("s%0d c%0d merged", id, e + 1), {31'd0, merged}, {31'd0, mg});
    end
    req   = 4'b0000;
    mute  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(); run_scn(1, 20);
    do_reset(); run_scn(2, 20);
    do_reset(); run_scn(3, 50);
    do_reset(); run_scn(4, 28);
    do_reset(); run_scn(5, 34);
    do_reset(); run_scn(6, 25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
